barrel_shift_pipe: RTL

Parametrised, pipelined barrel shifter: a WIDTH-bit operand is shifted or rotated by a runtime amount in one of four modes, one power-of-two shift stage per pipeline register. Each stage is a column of 2:1 mux cells selected by one shift-amount bit. Valid/ready handshakes on both sides sustain one operation per cycle under backpressure. It sits between the datapath register file and the result bus, in place of the fixed 8-bit combinational shifter.

---
 rtl/barrel_shift_pipe.sv | 135 +++++++++++++
 1 files changed

// File: rtl/barrel_shift_pipe.sv
// barrel_shift_pipe: pipelined WIDTH-bit barrel shifter / rotator.
// One power-of-two shift stage per pipeline register (stage k shifts by 2^k
// when bit k of the shift amount is set). Valid/ready handshakes on both
// sides; a single global advance enable moves the whole pipe or holds it.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   input operation present
//   in_ready   block accepts input this cycle (combinational: !out_valid || out_ready)
//   in_data    operand
//   in_shamt   shift amount, 0..WIDTH-1
//   in_mode    00 LSL, 01 LSR, 10 ASR, 11 ROR
//   out_valid  result present
//   out_ready  consumer accepts result
//   out_data   shifted result
//   out_zero   out_data == 0, qualified by out_valid
module barrel_shift_pipe #(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  localparam logic [1:0] MODE_LSL = 2'b00;
  localparam logic [1:0] MODE_LSR = 2'b01;
  localparam logic [1:0] MODE_ASR = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  localparam logic [WIDTH-1:0] ONES = '1;

  // Pipeline stage registers
  logic [WIDTH-1:0] r_data  [SHW];
  logic [SHW-1:0]   r_shamt [SHW];
  logic [1:0]       r_mode  [SHW];
  logic             r_sign  [SHW];
  logic             r_valid [SHW];
  logic             r_zero;

  // Per-stage source (previous stage or inputs) and next value
  logic [WIDTH-1:0] w_src_data  [SHW];
  logic [SHW-1:0]   w_src_shamt [SHW];
  logic [1:0]       w_src_mode  [SHW];
  logic             w_src_sign  [SHW];
  logic             w_src_valid [SHW];
  logic [WIDTH-1:0] w_nxt_data  [SHW];
  logic             w_en;

  // Single shift step by a fixed amount; the sign used by ASR is the
  // operand MSB captured at acceptance, so partial shifts compose correctly.
  function automatic logic [WIDTH-1:0] f_shift(
    input logic [WIDTH-1:0] d,
    input int unsigned      amt,
    input logic [1:0]       mode,
    input logic             sgn
  );
    logic [WIDTH-1:0] res;
    res = d;
    case (mode)
      MODE_LSL: res = d << amt;
      MODE_LSR: res = d >> amt;
      MODE_ASR: res = (d >> amt) | (sgn ? ~(ONES >> amt) : '0);
      MODE_ROR: res = (d >> amt) | (d << (WIDTH - amt));
      default:  res = d;
    endcase
    return res;
  endfunction

  // Whole pipe advances when the output slot is empty or being drained
  assign w_en     = !r_valid[SHW-1] || out_ready;
  assign in_ready = w_en;

  // Stage wiring: stage 0 is fed from the inputs, stage k from stage k-1
  for (genvar k = 0; k < SHW; k++) begin : g_stage
    localparam int unsigned AMT = 2 ** k;

    if (k == 0) begin : g_src_in
      assign w_src_data[k]  = in_data;
      assign w_src_shamt[k] = in_shamt;
      assign w_src_mode[k]  = in_mode;
      assign w_src_sign[k]  = in_data[WIDTH-1];
      assign w_src_valid[k] = in_valid && w_en;
    end else begin : g_src_reg
      assign w_src_data[k]  = r_data[k-1];
      assign w_src_shamt[k] = r_shamt[k-1];
      assign w_src_mode[k]  = r_mode[k-1];
      assign w_src_sign[k]  = r_sign[k-1];
      assign w_src_valid[k] = r_valid[k-1];
    end

    // Remaining shift amount is kept LSB-aligned, so bit 0 selects this stage
    assign w_nxt_data[k] = w_src_shamt[k][0]
                         ? f_shift(w_src_data[k], AMT, w_src_mode[k], w_src_sign[k])
                         : w_src_data[k];
  end

  // Stage registers; reset discards all in-flight operations
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < SHW; k++) begin
        r_data[k]  <= '0;
        r_shamt[k] <= '0;
        r_mode[k]  <= MODE_LSL;
        r_sign[k]  <= 1'b0;
        r_valid[k] <= 1'b0;
      end
      r_zero <= 1'b0;
    end else if (w_en) begin
      for (int unsigned k = 0; k < SHW; k++) begin
        r_data[k]  <= w_nxt_data[k];
        r_shamt[k] <= w_src_shamt[k] >> 1;
        r_mode[k]  <= w_src_mode[k];
        r_sign[k]  <= w_src_sign[k];
        r_valid[k] <= w_src_valid[k];
      end
      // Zero flag registered alongside the last stage from its next value
      r_zero <= (w_nxt_data[SHW-1] == '0);
    end
  end

  assign out_valid = r_valid[SHW-1];
  assign out_data  = r_data[SHW-1];
  assign out_zero  = r_zero;

endmodule
